// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multi-cycle MIPS control unit.
// States, instruction classes, opcode/funct constants, ALUop codes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b101
  } state_e;

  typedef enum logic [3:0] {
    C_RALU,
    C_JR,
    C_IMM,
    C_LW,
    C_SW,
    C_BEQ,
    C_BNE,
    C_J,
    C_JAL,
    C_HALT,
    C_UNDEF
  } cls_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_SLL  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_SLTU = 3'b101;
  localparam logic [2:0] ALU_SLT  = 3'b110;
  localparam logic [2:0] ALU_NOR  = 3'b111;

  localparam logic [1:0] RD_RA = 2'b00;
  localparam logic [1:0] RD_RT = 2'b01;
  localparam logic [1:0] RD_RD = 2'b10;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_RS  = 2'b10;
  localparam logic [1:0] PC_JMP = 2'b11;

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// multi_cycle_ctrl_if: instruction fields in, datapath controls out.
// master drives op/funct/zero; slave (the controller) drives the rest.
interface multi_cycle_ctrl_if;

  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic [2:0] ALUop;
  logic       ALUSrcA;
  logic       ALUSrcB;
  logic       ExtSel;
  logic [1:0] RegDst;
  logic       RegWre;
  logic       IRWre;
  logic       PCWre;
  logic       mRD;
  logic       mWR;
  logic       DBDataSrc;
  logic [1:0] PCSrc;
  logic [2:0] State;

  modport master (
    output op, funct, zero,
    input  ALUop, ALUSrcA, ALUSrcB, ExtSel,
    input  RegDst, RegWre, IRWre, PCWre,
    input  mRD, mWR, DBDataSrc, PCSrc, State
  );

  modport slave (
    input  op, funct, zero,
    output ALUop, ALUSrcA, ALUSrcB, ExtSel,
    output RegDst, RegWre, IRWre, PCWre,
    output mRD, mWR, DBDataSrc, PCSrc, State
  );

endinterface

// File: rtl/ctrl_decode.sv
// ctrl_decode: op/funct -> instruction class and state-independent controls.
// Ports: op, funct in; cls, aluop, alusrca/b, extsel, regdst, dbdatasrc out.
// CTRL_JAL_JR_EN enables jal/jr; without it they decode as undefined.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output cls_e       cls,
  output logic [2:0] aluop,
  output logic       alusrca,
  output logic       alusrcb,
  output logic       extsel,
  output logic [1:0] regdst,
  output logic       dbdatasrc
);

  always_comb begin
    cls       = C_UNDEF;
    aluop     = ALU_ADD;
    alusrca   = 1'b0;
    alusrcb   = 1'b0;
    extsel    = 1'b1;
    regdst    = RD_RT;
    dbdatasrc = 1'b0;
    unique case (1'b1)
      (op == OP_RTYPE): begin
        regdst = RD_RD;
        cls    = C_RALU;
        unique case (funct)
          FN_ADD:  aluop = ALU_ADD;
          FN_SUB:  aluop = ALU_SUB;
          FN_AND:  aluop = ALU_AND;
          FN_OR:   aluop = ALU_OR;
          FN_NOR:  aluop = ALU_NOR;
          FN_SLT:  aluop = ALU_SLT;
          FN_SLTU: aluop = ALU_SLTU;
          FN_SLL: begin
            aluop   = ALU_SLL;
            alusrca = 1'b1;
          end
`ifdef CTRL_JAL_JR_EN
          FN_JR:   cls = C_JR;
`endif
          default: cls = C_UNDEF;
        endcase
      end
      (op == OP_ADDIU): begin
        cls     = C_IMM;
        alusrcb = 1'b1;
      end
      (op == OP_ANDI): begin
        cls     = C_IMM;
        aluop   = ALU_AND;
        alusrcb = 1'b1;
        extsel  = 1'b0;
      end
      (op == OP_ORI): begin
        cls     = C_IMM;
        aluop   = ALU_OR;
        alusrcb = 1'b1;
        extsel  = 1'b0;
      end
      (op == OP_SLTI): begin
        cls     = C_IMM;
        aluop   = ALU_SLT;
        alusrcb = 1'b1;
      end
      (op == OP_SLTIU): begin
        cls     = C_IMM;
        aluop   = ALU_SLTU;
        alusrcb = 1'b1;
      end
      (op == OP_LW): begin
        cls       = C_LW;
        alusrcb   = 1'b1;
        dbdatasrc = 1'b1;
      end
      (op == OP_SW): begin
        cls     = C_SW;
        alusrcb = 1'b1;
      end
      (op == OP_BEQ): begin
        cls   = C_BEQ;
        aluop = ALU_SUB;
      end
      (op == OP_BNE): begin
        cls   = C_BNE;
        aluop = ALU_SUB;
      end
      (op == OP_J): cls = C_J;
`ifdef CTRL_JAL_JR_EN
      (op == OP_JAL): begin
        cls    = C_JAL;
        regdst = RD_RA;
      end
`endif
      (op == OP_HALT): cls = C_HALT;
      default: cls = C_UNDEF;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: IF/ID/EXE/MEM/WB/HALT control FSM for a multi-cycle MIPS.
// Ports: CLK, Reset (sync, active high), bus (slave: op/funct/zero in, controls out).
// Option: CTRL_JAL_JR_EN enables jal/jr (see ctrl_decode).
module multi_cycle_ctrl
  import ctrl_pkg::*;
(
  input logic          CLK,
  input logic          Reset,
  multi_cycle_ctrl_if.slave bus
);

  state_e     state;
  cls_e       cls;
  logic [2:0] aluop;
  logic       alusrca;
  logic       alusrcb;
  logic       extsel;
  logic [1:0] regdst;
  logic       dbdatasrc;
  logic       jmp_cls;
  logic       br_cls;
  logic       taken;
  logic       irwre;
  logic       pcwre;
  logic       regwre;
  logic       mrd;
  logic       mwr;
  logic [1:0] pcsrc;

  ctrl_decode u_dec (
    .op        (bus.op),
    .funct     (bus.funct),
    .cls       (cls),
    .aluop     (aluop),
    .alusrca   (alusrca),
    .alusrcb   (alusrcb),
    .extsel    (extsel),
    .regdst    (regdst),
    .dbdatasrc (dbdatasrc)
  );

  // Undefined instructions retire in ID exactly like a jump to PC+4.
  assign jmp_cls = (cls == C_J) || (cls == C_JAL) ||
                   (cls == C_JR) || (cls == C_UNDEF);
  assign br_cls  = (cls == C_BEQ) || (cls == C_BNE);
  assign taken   = ((cls == C_BEQ) && bus.zero) ||
                   ((cls == C_BNE) && !bus.zero);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= S_IF;
    end else begin
      unique case (state)
        S_IF: state <= S_ID;
        S_ID: begin
          if (jmp_cls)
            state <= S_IF;
          else if (cls == C_HALT)
            state <= S_HALT;
          else
            state <= S_EXE;
        end
        S_EXE: begin
          if (br_cls)
            state <= S_IF;
          else if ((cls == C_LW) || (cls == C_SW))
            state <= S_MEM;
          else
            state <= S_WB;
        end
        S_MEM: begin
          if (cls == C_SW)
            state <= S_IF;
          else
            state <= S_WB;
        end
        S_WB:   state <= S_IF;
        S_HALT: state <= S_HALT;
        default: state <= S_IF;
      endcase
    end
  end

  // Only writers reach WB, so WB alone implies a register write.
  always_comb begin
    irwre  = 1'b0;
    pcwre  = 1'b0;
    regwre = 1'b0;
    mrd    = 1'b0;
    mwr    = 1'b0;
    pcsrc  = PC_SEQ;
    unique case (state)
      S_IF: irwre = 1'b1;
      S_ID: begin
        pcwre  = jmp_cls;
        regwre = (cls == C_JAL);
        if ((cls == C_J) || (cls == C_JAL))
          pcsrc = PC_JMP;
        else if (cls == C_JR)
          pcsrc = PC_RS;
      end
      S_EXE: begin
        pcwre = br_cls;
        if (taken)
          pcsrc = PC_BR;
      end
      S_MEM: begin
        mrd   = (cls == C_LW);
        mwr   = (cls == C_SW);
        pcwre = (cls == C_SW);
      end
      S_WB: begin
        pcwre  = 1'b1;
        regwre = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.ALUop     = aluop;
  assign bus.ALUSrcA   = alusrca;
  assign bus.ALUSrcB   = alusrcb;
  assign bus.ExtSel    = extsel;
  assign bus.RegDst    = regdst;
  assign bus.DBDataSrc = dbdatasrc;
  assign bus.IRWre     = irwre;
  assign bus.PCWre     = pcwre;
  assign bus.RegWre    = regwre;
  assign bus.mRD       = mrd;
  assign bus.mWR       = mwr;
  assign bus.PCSrc     = pcsrc;
  assign bus.State     = state;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb_multi_cycle_ctrl: table vectors, corner sequences and random
// instruction streams checked against an instruction-level model.
module tb_multi_cycle_ctrl;

  logic CLK = 1'b0;
  logic Reset;
  int   n_chk = 0;
  int   n_fail = 0;

  multi_cycle_ctrl_if bus();

  multi_cycle_ctrl dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

`ifdef CTRL_JAL_JR_EN
  localparam bit JAL_JR = 1'b1;
`else
  localparam bit JAL_JR = 1'b0;
`endif

  typedef struct {
    bit       known;
    bit [2:0] alu;
    bit       srca;
    bit       srcb;
    bit       ext;
    bit       dbsrc;
    bit [1:0] dst;
    bit       wr;
    bit       halt;
    bit       jump;
    bit       br;
    bit       bne;
    bit       lw;
    bit       sw;
    bit [1:0] jtgt;
  } info_t;

  typedef struct {
    bit [5:0] op;
    bit [5:0] fn;
    bit       z;
    int       cycles;
    int       alu;
    int       pcsrc;
    bit       wr;
    int       dst;
  } vec_t;

  vec_t tv[$];
  bit [11:0] pool [20];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic info_t alu_i(bit [2:0] a, bit [1:0] d, bit b);
    info_t r;
    r = '{default: 0};
    r.known = 1'b1;
    r.ext   = 1'b1;
    r.wr    = 1'b1;
    r.alu   = a;
    r.dst   = d;
    r.srcb  = b;
    return r;
  endfunction

  function automatic info_t ref_info(input bit [5:0] op, input bit [5:0] fn);
    info_t r;
    r = '{default: 0};
    r.ext  = 1'b1;
    r.jump = 1'b1;
    case (op)
      6'b000000: begin
        case (fn)
          6'b100000: r = alu_i(3'd0, 2'd2, 1'b0);
          6'b100010: r = alu_i(3'd1, 2'd2, 1'b0);
          6'b000000: begin
            r = alu_i(3'd2, 2'd2, 1'b0);
            r.srca = 1'b1;
          end
          6'b100101: r = alu_i(3'd3, 2'd2, 1'b0);
          6'b100100: r = alu_i(3'd4, 2'd2, 1'b0);
          6'b101011: r = alu_i(3'd5, 2'd2, 1'b0);
          6'b101010: r = alu_i(3'd6, 2'd2, 1'b0);
          6'b100111: r = alu_i(3'd7, 2'd2, 1'b0);
          6'b001000: if (JAL_JR) r.jtgt = 2'd2;
          default: ;
        endcase
      end
      6'b001001: r = alu_i(3'd0, 2'd1, 1'b1);
      6'b001100: begin
        r = alu_i(3'd4, 2'd1, 1'b1);
        r.ext = 1'b0;
      end
      6'b001101: begin
        r = alu_i(3'd3, 2'd1, 1'b1);
        r.ext = 1'b0;
      end
      6'b001010: r = alu_i(3'd6, 2'd1, 1'b1);
      6'b001011: r = alu_i(3'd5, 2'd1, 1'b1);
      6'b100011: begin
        r = alu_i(3'd0, 2'd1, 1'b1);
        r.lw = 1'b1;
        r.dbsrc = 1'b1;
      end
      6'b101011: begin
        r = alu_i(3'd0, 2'd1, 1'b1);
        r.wr = 1'b0;
        r.sw = 1'b1;
      end
      6'b000100, 6'b000101: begin
        r = alu_i(3'd1, 2'd1, 1'b0);
        r.wr = 1'b0;
        r.br = 1'b1;
        r.bne = op[0];
      end
      6'b000010: r.jtgt = 2'd3;
      6'b000011: begin
        if (JAL_JR) begin
          r.jtgt = 2'd3;
          r.wr = 1'b1;
          r.dst = 2'd0;
        end
      end
      6'b111111: begin
        r.jump = 1'b0;
        r.halt = 1'b1;
      end
      default: ;
    endcase
    return r;
  endfunction

  // Number of cycles from IF until the instruction retires.
  function automatic int plen_of(info_t r);
    if (r.jump) return 2;
    if (r.halt || r.br) return 3;
    if (r.sw) return 4;
    if (r.lw) return 5;
    return 4;
  endfunction

  // State visited at cycle k of the instruction (IF=0 ... HALT=5).
  function automatic int st_at(info_t r, int k);
    if (k < 2) return k;
    if (r.halt) return 5;
    if (k == 2) return 2;
    if (k == 3) return (r.lw || r.sw) ? 3 : 4;
    return 4;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, " rst State"}, bus.State, 0);
    chk({tag, " rst IRWre"}, bus.IRWre, 1);
    chk({tag, " rst PCWre"}, bus.PCWre, 0);
    chk({tag, " rst RegWre"}, bus.RegWre, 0);
    chk({tag, " rst mRD"}, bus.mRD, 0);
    chk({tag, " rst mWR"}, bus.mWR, 0);
    chk({tag, " rst PCSrc"}, bus.PCSrc, 0);
  endtask

  task automatic check_cycle(input info_t r, input int k, input bit z,
                             input string tag);
    int st;
    bit last;
    bit taken;
    int pcs;
    st    = st_at(r, k);
    last  = (k == plen_of(r) - 1) && !r.halt;
    taken = r.br && (r.bne ? !z : z);
    pcs   = !last ? 0 : r.jump ? int'(r.jtgt) : taken ? 1 : 0;
    chk($sformatf("%s k%0d State", tag, k), bus.State, st);
    chk($sformatf("%s k%0d IRWre", tag, k), bus.IRWre, int'(k == 0));
    chk($sformatf("%s k%0d PCWre", tag, k), bus.PCWre, int'(last));
    chk($sformatf("%s k%0d RegWre", tag, k), bus.RegWre, int'(last && r.wr));
    chk($sformatf("%s k%0d mRD", tag, k), bus.mRD, int'(st == 3 && r.lw));
    chk($sformatf("%s k%0d mWR", tag, k), bus.mWR, int'(st == 3 && r.sw));
    chk($sformatf("%s k%0d PCSrc", tag, k), bus.PCSrc, pcs);
    chk($sformatf("%s k%0d ALUSrcA", tag, k), bus.ALUSrcA, int'(r.srca));
    chk($sformatf("%s k%0d ALUSrcB", tag, k), bus.ALUSrcB, int'(r.srcb));
    chk($sformatf("%s k%0d ExtSel", tag, k), bus.ExtSel, int'(r.ext));
    chk($sformatf("%s k%0d DBDataSrc", tag, k), bus.DBDataSrc, int'(r.dbsrc));
    if (r.known)
      chk($sformatf("%s k%0d ALUop", tag, k), bus.ALUop, int'(r.alu));
    if (last && r.wr)
      chk($sformatf("%s k%0d RegDst", tag, k), bus.RegDst, int'(r.dst));
  endtask

  // Runs one instruction from IF; optional reset after cycle rst_at.
  task automatic run_instr(input bit [5:0] op, input bit [5:0] fn,
                           input bit z, input int rst_at, input int hold,
                           input string tag);
    info_t r;
    int n;
    r = ref_info(op, fn);
    n = plen_of(r) + (r.halt ? hold : 0);
    bus.op = op;
    bus.funct = fn;
    bus.zero = z;
    #1;
    for (int k = 0; k < n; k++) begin
      check_cycle(r, k, z, tag);
      if (k == rst_at || (r.halt && k == n - 1)) begin
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check_reset(tag);
        return;
      end
      tick();
    end
    chk({tag, " back to IF"}, bus.State, 0);
  endtask

  initial begin
    Reset = 1'b1;
    bus.op = 6'd0;
    bus.funct = 6'd0;
    bus.zero = 1'b0;

    tv.push_back('{6'b000000, 6'b100000, 1'b0, 4, 0, 0, 1'b1, 2});
    tv.push_back('{6'b000000, 6'b100010, 1'b0, 4, 1, 0, 1'b1, 2});
    tv.push_back('{6'b000000, 6'b000000, 1'b0, 4, 2, 0, 1'b1, 2});
    tv.push_back('{6'b000000, 6'b100101, 1'b0, 4, 3, 0, 1'b1, 2});
    tv.push_back('{6'b000000, 6'b100100, 1'b0, 4, 4, 0, 1'b1, 2});
    tv.push_back('{6'b000000, 6'b101011, 1'b0, 4, 5, 0, 1'b1, 2});
    tv.push_back('{6'b000000, 6'b101010, 1'b0, 4, 6, 0, 1'b1, 2});
    tv.push_back('{6'b000000, 6'b100111, 1'b0, 4, 7, 0, 1'b1, 2});
    tv.push_back('{6'b001001, 6'b000000, 1'b0, 4, 0, 0, 1'b1, 1});
    tv.push_back('{6'b001100, 6'b000000, 1'b0, 4, 4, 0, 1'b1, 1});
    tv.push_back('{6'b001101, 6'b000000, 1'b0, 4, 3, 0, 1'b1, 1});
    tv.push_back('{6'b001010, 6'b000000, 1'b0, 4, 6, 0, 1'b1, 1});
    tv.push_back('{6'b001011, 6'b000000, 1'b0, 4, 5, 0, 1'b1, 1});
    tv.push_back('{6'b100011, 6'b000000, 1'b0, 5, 0, 0, 1'b1, 1});
    tv.push_back('{6'b101011, 6'b000000, 1'b0, 4, 0, 0, 1'b0, 0});
    tv.push_back('{6'b000100, 6'b000000, 1'b1, 3, 1, 1, 1'b0, 0});
    tv.push_back('{6'b000100, 6'b000000, 1'b0, 3, 1, 0, 1'b0, 0});
    tv.push_back('{6'b000101, 6'b000000, 1'b0, 3, 1, 1, 1'b0, 0});
    tv.push_back('{6'b000101, 6'b000000, 1'b1, 3, 1, 0, 1'b0, 0});
    tv.push_back('{6'b000010, 6'b000000, 1'b0, 2, -1, 3, 1'b0, 0});
`ifdef CTRL_JAL_JR_EN
    tv.push_back('{6'b000011, 6'b000000, 1'b0, 2, -1, 3, 1'b1, 0});
    tv.push_back('{6'b000000, 6'b001000, 1'b0, 2, -1, 2, 1'b0, 0});
`else
    tv.push_back('{6'b000011, 6'b000000, 1'b0, 2, -1, 0, 1'b0, 0});
    tv.push_back('{6'b000000, 6'b001000, 1'b0, 2, -1, 0, 1'b0, 0});
`endif
    tv.push_back('{6'b010000, 6'b000000, 1'b0, 2, -1, 0, 1'b0, 0});
    tv.push_back('{6'b000000, 6'b111111, 1'b0, 2, -1, 0, 1'b0, 0});

    pool = '{
      {6'b000000, 6'b100000}, {6'b000000, 6'b100010},
      {6'b000000, 6'b100100}, {6'b000000, 6'b100101},
      {6'b000000, 6'b100111}, {6'b000000, 6'b101010},
      {6'b000000, 6'b101011}, {6'b000000, 6'b000000},
      {6'b000000, 6'b001000}, {6'b001001, 6'b000000},
      {6'b001100, 6'b000000}, {6'b001101, 6'b000000},
      {6'b001010, 6'b000000}, {6'b001011, 6'b000000},
      {6'b100011, 6'b000000}, {6'b101011, 6'b000000},
      {6'b000100, 6'b000000}, {6'b000101, 6'b000000},
      {6'b000010, 6'b000000}, {6'b000011, 6'b000000}
    };

    tick();
    tick();
    Reset = 1'b0;
    check_reset("init");

    for (int i = 0; i < tv.size(); i++) begin
      int n;
      int np;
      int pcs;
      int w;
      int d;
      int alu;
      bus.op = tv[i].op;
      bus.funct = tv[i].fn;
      bus.zero = tv[i].z;
      #1;
      alu = bus.ALUop;
      pcs = -1;
      w = 0;
      d = -1;
      n = 0;
      np = 0;
      do begin
        if (bus.PCWre) begin
          np++;
          pcs = bus.PCSrc;
          w = bus.RegWre;
          d = bus.RegDst;
        end
        tick();
        n++;
      end while (bus.State != 0 && n < 8);
      chk($sformatf("tv%0d cycles", i), n, tv[i].cycles);
      chk($sformatf("tv%0d PCWre pulses", i), np, 1);
      chk($sformatf("tv%0d PCSrc", i), pcs, tv[i].pcsrc);
      chk($sformatf("tv%0d RegWre", i), w, int'(tv[i].wr));
      if (tv[i].alu >= 0)
        chk($sformatf("tv%0d ALUop", i), alu, tv[i].alu);
      if (tv[i].wr)
        chk($sformatf("tv%0d RegDst", i), d, tv[i].dst);
    end

    run_instr(6'b000000, 6'b100000, 1'b0, -1, 0, "add");
    run_instr(6'b000100, 6'b000000, 1'b1, -1, 0, "beq_t");
    run_instr(6'b000100, 6'b000000, 1'b0, -1, 0, "beq_nt");
    run_instr(6'b100011, 6'b000000, 1'b0, -1, 0, "lw");
    run_instr(6'b000011, 6'b000000, 1'b0, -1, 0, "jal");
    run_instr(6'b111111, 6'b000000, 1'b0, -1, 10, "halt");
    run_instr(6'b101011, 6'b000000, 1'b0, 3, 0, "sw_rst_mem");
    run_instr(6'b100011, 6'b000000, 1'b0, 4, 0, "lw_rst_wb");
    run_instr(6'b001101, 6'b000000, 1'b0, 2, 0, "ori_rst_exe");
    run_instr(6'b000000, 6'b100010, 1'b0, 3, 0, "sub_rst_wb");

    for (int i = 0; i < 400; i++) begin
      int idx;
      int ra;
      bit [5:0] o;
      bit [5:0] f;
      idx = $urandom_range(0, 24);
      if (idx < 20) begin
        o = pool[idx][11:6];
        f = pool[idx][5:0];
      end else if (idx == 23) begin
        o = 6'b111111;
        f = 6'($urandom);
      end else if (idx == 24) begin
        o = 6'b000000;
        f = 6'($urandom);
      end else begin
        o = 6'($urandom);
        f = 6'($urandom);
      end
      ra = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(o, f, 1'($urandom), ra, int'($urandom_range(0, 3)),
                $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
